// File: rtl/acc_stream_feeder_if.sv
// acc_stream_feeder_if: host write port, flush control, status and the
// X1..X4/valid/ready stream toward acc_pipe.
// The slave modport is the feeder; the master modport is the host/consumer side.
interface acc_stream_feeder_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) ();
  logic             wr_en;
  logic [WIDTH-1:0] wr_X1;
  logic [WIDTH-1:0] wr_X2;
  logic [WIDTH-1:0] wr_X3;
  logic [WIDTH-1:0] wr_X4;
  logic             full;
  logic             ovf;
  logic             flush;
  logic [AW:0]      level;
  logic [WIDTH-1:0] X1;
  logic [WIDTH-1:0] X2;
  logic [WIDTH-1:0] X3;
  logic [WIDTH-1:0] X4;
  logic             valid;
  logic             ready;

  modport slave (
    input  wr_en, wr_X1, wr_X2, wr_X3, wr_X4, flush, ready,
    output full, ovf, level, X1, X2, X3, X4, valid
  );

  modport master (
    output wr_en, wr_X1, wr_X2, wr_X3, wr_X4, flush, ready,
    input  full, ovf, level, X1, X2, X3, X4, valid
  );
endinterface

// File: rtl/acc_stream_feeder.sv
// acc_stream_feeder: first-word-fall-through FIFO of 4-lane signed vectors
// feeding acc_pipe with valid/ready, plus sticky overflow flag and flush.
// Optional feature macro: ACC_FEEDER_CNT_EN adds the sent_cnt transfer counter.
// level is the authoritative occupancy; valid and full are decoded from it,
// so no output has a combinational path from ready or wr_en.
module acc_stream_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  arst_n,
  acc_stream_feeder_if.slave    bus
`ifdef ACC_FEEDER_CNT_EN
  ,
  output logic [15:0]           sent_cnt
`endif
);

  localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0] LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [4*WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;

  logic          valid_s;
  logic          full_s;
  logic          do_rd_s;
  logic          do_wr_s;
  logic [4*WIDTH-1:0] head_s;
  logic [4*WIDTH-1:0] wdata_s;

  assign valid_s = (level_q != LVL_ZERO);
  assign full_s  = (level_q == LVL_FULL);
  assign do_rd_s = valid_s && bus.ready;
  assign do_wr_s = bus.wr_en && !full_s;
  assign wdata_s = {bus.wr_X4, bus.wr_X3, bus.wr_X2, bus.wr_X1};
  assign head_s  = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and sticky overflow (flush handled in the register block).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // A dropped write flags overflow even when a read frees a slot this same cycle.
    if (bus.wr_en && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    case ({do_wr_s, do_rd_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control state registers: reset first, then flush, then normal update.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      level_q  <= LVL_ZERO;
      ovf_q    <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      level_q  <= LVL_ZERO;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Vector storage; contents are only visible through valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (arst_n && !bus.flush && do_wr_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  assign bus.valid = valid_s;
  assign bus.full  = full_s;
  assign bus.level = level_q;
  assign bus.ovf   = ovf_q;
  assign bus.X1    = valid_s ? head_s[1*WIDTH-1:0*WIDTH] : {WIDTH{1'b0}};
  assign bus.X2    = valid_s ? head_s[2*WIDTH-1:1*WIDTH] : {WIDTH{1'b0}};
  assign bus.X3    = valid_s ? head_s[3*WIDTH-1:2*WIDTH] : {WIDTH{1'b0}};
  assign bus.X4    = valid_s ? head_s[4*WIDTH-1:3*WIDTH] : {WIDTH{1'b0}};

`ifdef ACC_FEEDER_CNT_EN
  logic [15:0] sent_cnt_q;

  // Completed-transfer counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      sent_cnt_q <= 16'd0;
    end else if (bus.flush) begin
      sent_cnt_q <= 16'd0;
    end else if (do_rd_s) begin
      sent_cnt_q <= sent_cnt_q + 16'd1;
    end else begin
      sent_cnt_q <= sent_cnt_q;
    end
  end

  assign sent_cnt = sent_cnt_q;
`endif

endmodule

// File: tb/tb_acc_stream_feeder.sv
// Self-checking bench for acc_stream_feeder: a queue scoreboard holds every
// accepted vector; each cycle the DUT outputs are compared against it before
// the clock edge, then the model applies the same edge.
module tb_acc_stream_feeder;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic arst_n;
`ifdef ACC_FEEDER_CNT_EN
  logic [15:0] sent_cnt;
  int          exp_cnt;
`endif

  acc_stream_feeder_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  acc_stream_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
`ifdef ACC_FEEDER_CNT_EN
    ,
    .sent_cnt (sent_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sb_q [$];
  logic        exp_ovf;
  int          n_checks;
  int          n_fail;
  bit          chk_en;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_wr(input bit en, input logic [31:0] v);
    bus.wr_en = en;
    {bus.wr_X4, bus.wr_X3, bus.wr_X2, bus.wr_X1} = v;
  endtask

  function automatic logic [31:0] mkvec(input int a, input int b, input int c, input int d);
    logic [7:0] x1, x2, x3, x4;
    x1 = 8'(a); x2 = 8'(b); x3 = 8'(c); x4 = 8'(d);
    return {x4, x3, x2, x1};
  endfunction

  // One clock: compare outputs against the model, advance the model, cross the edge.
  task automatic cyc();
    logic [31:0] exp_x;
    int sz;
    bit rd, wr;
    @(negedge clk);
    sz = sb_q.size();
    if (chk_en) begin
      exp_x = (sz != 0) ? sb_q[0] : 32'd0;
      check("valid", {31'd0, bus.valid}, {31'd0, sz != 0});
      check("level", {28'd0, bus.level}, 32'(sz));
      check("full",  {31'd0, bus.full},  {31'd0, sz == DEPTH});
      check("ovf",   {31'd0, bus.ovf},   {31'd0, exp_ovf});
      check("X",     {bus.X4, bus.X3, bus.X2, bus.X1}, exp_x);
`ifdef ACC_FEEDER_CNT_EN
      check("sent_cnt", {16'd0, sent_cnt}, 32'(exp_cnt[15:0]));
`endif
    end
    if (!arst_n || bus.flush) begin
      sb_q.delete();
      exp_ovf = 1'b0;
`ifdef ACC_FEEDER_CNT_EN
      exp_cnt = 0;
`endif
    end else begin
      rd = (sz != 0) && bus.ready;
      wr = bus.wr_en && (sz != DEPTH);
      if (bus.wr_en && sz == DEPTH) exp_ovf = 1'b1;
      if (rd) begin
        void'(sb_q.pop_front());
`ifdef ACC_FEEDER_CNT_EN
        exp_cnt++;
`endif
      end
      if (wr) sb_q.push_back({bus.wr_X4, bus.wr_X3, bus.wr_X2, bus.wr_X1});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_ovf  = 1'b0;
    chk_en   = 1'b0;
`ifdef ACC_FEEDER_CNT_EN
    exp_cnt  = 0;
`endif
    // Reset held two cycles with a write strobe active
    arst_n    = 1'b0;
    bus.flush = 1'b0;
    bus.ready = 1'b0;
    set_wr(1'b1, mkvec(85, 85, 85, 85));
    cyc();
    chk_en = 1'b1;
    cyc();
    arst_n = 1'b1;
    set_wr(1'b0, 32'd0);
    cyc();

    // Single vector with ready high: one-cycle latency, then drained
    bus.ready = 1'b1;
    set_wr(1'b1, mkvec(10, -20, 30, -40));
    cyc();
    set_wr(1'b0, 32'd0);
    cyc();
    cyc();

    // Back-pressure: fill to full, one dropped write, then drain in order
    bus.ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      set_wr(1'b1, mkvec(i, -i, i + 100, -i - 100));
      cyc();
    end
    set_wr(1'b0, 32'd0);
    cyc();
    bus.ready = 1'b1;
    for (int i = 0; i < 9; i++) cyc();

    // Simultaneous read and write at level 3 across pointer wrap
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, mkvec(20 + i, -1, 127, -128));
      cyc();
    end
    bus.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_wr(1'b1, mkvec(40 + i, -2, -128, 127));
      cyc();
    end
    set_wr(1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cyc();

    // Flush with level 5 and ovf set, concurrent write discarded
    bus.ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_wr(1'b1, mkvec(60 + i, 1, 2, 3));
      cyc();
    end
    set_wr(1'b0, 32'd0);
    bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    bus.ready = 1'b0;
    bus.flush = 1'b1;
    set_wr(1'b1, mkvec(-5, -6, -7, -8));
    cyc();
    bus.flush = 1'b0;
    set_wr(1'b0, 32'd0);
    cyc();
    cyc();

    // Random streaming with random back-pressure
    for (int i = 0; i < 400; i++) begin
      set_wr(($urandom % 2) == 0, $urandom);
      bus.ready = ($urandom % 4) != 0;
      cyc();
    end
    set_wr(1'b0, 32'd0);
    bus.ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();

    // Reset mid-stream drops pending vectors
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, mkvec(i, i, i, i));
      cyc();
    end
    arst_n = 1'b0;
    set_wr(1'b0, 32'd0);
    cyc();
    arst_n = 1'b1;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
